inst_prefetch_queue: RTL and testbench



---
 rtl/inst_prefetch_queue.sv | 123 ++++++++++++
 tb/tb_inst_prefetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, requests sequential words from
// instruction memory and buffers {instr, pc+4} pairs in a circular queue whose head
// feeds decode. A redirect flushes the queue and restarts fetch at the new target.
// An empty queue presents a 32'b0 NOP with valid_o low.
// Optional feature: define PREFETCH_BYPASS_EN to forward an incoming word straight
// to the outputs when the queue is empty (zero fetch-to-decode latency).
`timescale 1ns / 1ps

module inst_prefetch_queue #(
  parameter int unsigned Depth   = 4,
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [31:0]                  imem_adr_o,
  output logic                         imem_req_o,
  input  logic                         imem_ready_i,
  input  logic [31:0]                  imem_rdata_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  input  logic                         deq_i,
  output logic [31:0]                  inst_o,
  output logic [31:0]                  pc_plus4_o,
  output logic                         valid_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [CW-1:0] CntFull = CW'(Depth);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  typedef enum logic {StBoot, StFetch} state_e;

  state_e        state_q;
  logic [31:0]   instr_q [Depth];
  logic [31:0]   pc4_q   [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   fetch_pc_q;

  logic          empty, req, push, pop, store, unload, valid;
  logic [31:0]   pc_next, head_instr, head_pc4;

  // Request/push/pop decode and head presentation.
  always_comb begin
    empty      = (count_q == '0);
    pc_next    = fetch_pc_q + 32'd4;
    // A pop in the same cycle frees a slot, so a full queue may still request.
    req        = (state_q == StFetch) && ((count_q != CntFull) || deq_i) && !redirect_i;
    push       = req && imem_ready_i;
    valid      = !empty;
    head_instr = empty ? 32'b0 : instr_q[rptr_q];
    head_pc4   = empty ? 32'b0 : pc4_q[rptr_q];
`ifdef PREFETCH_BYPASS_EN
    if (empty && push) begin
      valid      = 1'b1;
      head_instr = imem_rdata_i;
      head_pc4   = pc_next;
    end
`endif
    pop        = deq_i && valid && !redirect_i;
`ifdef PREFETCH_BYPASS_EN
    // A bypassed word consumed in the same cycle never enters storage.
    store      = push && !(empty && pop);
    unload     = pop && !empty;
`else
    store      = push;
    unload     = pop;
`endif
  end

  // Boot/fetch FSM together with the queue storage, pointers and fetch PC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StBoot;
      fetch_pc_q <= ResetPc;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        instr_q[i] <= '0;
        pc4_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        StBoot: state_q <= StFetch;
        StFetch: begin
          if (redirect_i) begin
            // Flush wins over any push or pop in this cycle.
            fetch_pc_q <= redirect_pc_i;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
          end else begin
            if (push) fetch_pc_q <= pc_next;
            if (store) begin
              instr_q[wptr_q] <= imem_rdata_i;
              pc4_q[wptr_q]   <= pc_next;
              wptr_q          <= wptr_q + PtrOne;
            end
            if (unload) rptr_q <= rptr_q + PtrOne;
            if (store && !unload) begin
              count_q <= count_q + CntOne;
            end else if (unload && !store) begin
              count_q <= count_q - CntOne;
            end
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign imem_adr_o = fetch_pc_q;
  assign imem_req_o = req;
  assign inst_o     = head_instr;
  assign pc_plus4_o = head_pc4;
  assign valid_o    = valid;
  assign count_o    = count_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue; instruction memory returns 0xC000_0000 | addr.
`timescale 1ns / 1ps

module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready, redirect, deq;
  logic [31:0] redirect_pc, imem_rdata;
  logic [31:0] imem_adr, inst, pc4;
  logic        imem_req, valid;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hC000_0000 | imem_adr;

  inst_prefetch_queue #(
    .Depth   (4),
    .ResetPc (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_adr_o    (imem_adr),
    .imem_req_o    (imem_req),
    .imem_ready_i  (imem_ready),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .deq_i         (deq),
    .inst_o        (inst),
    .pc_plus4_o    (pc4),
    .valid_o       (valid),
    .count_o       (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_adr"}, imem_adr, 32'h0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_pc4"}, pc4, 32'h0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; deq = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk_reset("rst");
    tick(); tick(); tick();
    chk("rst_hold_adr", imem_adr, 32'h0);
    chk("rst_hold_req", 32'(imem_req), 32'd0);

    // Boot cycle then streaming with deq=1.
    rst_n = 1'b1;
    #1;
    chk("boot_req", 32'(imem_req), 32'd0);
    chk("boot_adr", imem_adr, 32'h0);
    tick();
    chk("fetch_req", 32'(imem_req), 32'd1);
`ifndef PREFETCH_BYPASS_EN
    chk("fetch_valid0", 32'(valid), 32'd0);
`else
    chk("byp_valid", 32'(valid), 32'd1);
    chk("byp_inst", inst, 32'hC000_0000);
    chk("byp_pc4", pc4, 32'h4);
    chk("byp_count", 32'(count), 32'd0);
`endif
    tick();
    chk("s0_adr", imem_adr, 32'h4);
`ifndef PREFETCH_BYPASS_EN
    chk("s0_valid", 32'(valid), 32'd1);
    chk("s0_inst", inst, 32'hC000_0000);
    chk("s0_pc4", pc4, 32'h4);
    chk("s0_count", 32'(count), 32'd1);
`else
    chk("s0b_count", 32'(count), 32'd0);
    chk("s0b_inst", inst, 32'hC000_0004);
`endif
    tick();
`ifndef PREFETCH_BYPASS_EN
    chk("s1_inst", inst, 32'hC000_0004);
    chk("s1_pc4", pc4, 32'h8);
    chk("s1_count", 32'(count), 32'd1);
`else
    chk("s1b_inst", inst, 32'hC000_0008);
`endif
    tick();
    chk("s2_adr", imem_adr, 32'hC);
`ifndef PREFETCH_BYPASS_EN
    chk("s2_inst", inst, 32'hC000_0008);
    chk("s2_pc4", pc4, 32'hC);
`endif

    // Restart at 0 and fill with deq=0.
    redirect = 1'b1; redirect_pc = 32'h0; deq = 1'b0;
    #1;
    chk("redir_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("fill_start_count", 32'(count), 32'd0);
    chk("fill_start_adr", imem_adr, 32'h0);
    tick(); tick(); tick(); tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_adr", imem_adr, 32'h10);
    chk("full_inst", inst, 32'hC000_0000);
    chk("full_pc4", pc4, 32'h4);
    tick();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_adr", imem_adr, 32'h10);
    deq = 1'b1;
    #1;
    chk("full_deq_req", 32'(imem_req), 32'd1);
    tick();
    chk("pushpop_count", 32'(count), 32'd4);
    chk("pushpop_inst", inst, 32'hC000_0004);
    chk("pushpop_pc4", pc4, 32'h8);
    chk("pushpop_adr", imem_adr, 32'h14);

    // Drop to three entries, then redirect to 0x100 with deq=1.
    imem_ready = 1'b0;
    tick();
    chk("pop_only_count", 32'(count), 32'd3);
    chk("pop_only_inst", inst, 32'hC000_0008);
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("flush_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_adr", imem_adr, 32'h100);
    chk("flush_req_after", 32'(imem_req), 32'd1);
`ifndef PREFETCH_BYPASS_EN
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_inst", inst, 32'h0);
`endif
    tick();
    chk("tgt_adr", imem_adr, 32'h104);
`ifndef PREFETCH_BYPASS_EN
    chk("tgt_inst", inst, 32'hC000_0100);
    chk("tgt_pc4", pc4, 32'h104);
    chk("tgt_valid", 32'(valid), 32'd1);
`else
    chk("tgtb_count", 32'(count), 32'd0);
    chk("tgtb_inst", inst, 32'hC000_0104);
`endif

    // Memory wait: queue drains, deq on empty is ignored, address holds.
    imem_ready = 1'b0;
    tick();
    chk("wait0_count", 32'(count), 32'd0);
    chk("wait0_valid", 32'(valid), 32'd0);
    tick(); tick(); tick(); tick();
    chk("wait_count", 32'(count), 32'd0);
    chk("wait_valid", 32'(valid), 32'd0);
    chk("wait_inst", inst, 32'h0);
    chk("wait_pc4", pc4, 32'h0);
    chk("wait_adr", imem_adr, 32'h104);
    chk("wait_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1; deq = 1'b0;
    tick();
    chk("resume_count", 32'(count), 32'd1);
    chk("resume_inst", inst, 32'hC000_0104);
    chk("resume_pc4", pc4, 32'h108);
    chk("resume_adr", imem_adr, 32'h108);

    // Asynchronous reset mid-stream with two entries queued.
    tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_adr", imem_adr, 32'h10C);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    tick();
    deq = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("reboot_req", 32'(imem_req), 32'd0);
    tick();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_adr", imem_adr, 32'h0);
    tick();
    chk("refetch_adr4", imem_adr, 32'h4);
`ifndef PREFETCH_BYPASS_EN
    chk("refetch_inst", inst, 32'hC000_0000);
    chk("refetch_pc4", pc4, 32'h4);
`else
    chk("refetchb_inst", inst, 32'hC000_0004);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
